// File: rtl/cl_ddr_axi_responder.sv
// AXI4 responder backed by on-chip block RAM, standing in for a DDR channel.
// Services one read burst and one write burst concurrently, INCR addressing modulo memory depth.
module cl_ddr_axi_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int ID_W       = 16
) (
    input  logic              clk,
    input  logic              pipe_rst_n,
    input  logic [ID_W-1:0]   awid,
    input  logic [63:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic              awvalid,
    output logic              awready,
    input  logic [511:0]      wdata,
    input  logic [63:0]       wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ID_W-1:0]   arid,
    input  logic [63:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [511:0]      rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef logic [DEPTH_LOG2-1:0] idx_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    wstate_t         wstate_reg, wstate_next;
    logic [ID_W-1:0] wid_reg;
    idx_t            wbase_reg;
    logic [7:0]      wlen_reg;
    logic [7:0]      wcnt_reg;
    logic            werr_reg;
    logic            mem_we;
    idx_t            w_idx;

    rstate_t         rstate_reg, rstate_next;
    logic [ID_W-1:0] rid_reg;
    idx_t            rbase_reg;
    logic [7:0]      rlen_reg;
    logic [7:0]      rcnt_reg;
    logic            rerr_reg;
    logic            rd_en;
    idx_t            rd_idx;

    // Only the word-index bits of the byte addresses matter.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr[63:DEPTH_LOG2+6], awaddr[5:0],
                                araddr[63:DEPTH_LOG2+6], araddr[5:0]};

    // ---------------- write channel ----------------
    assign w_idx = wbase_reg + idx_t'(wcnt_reg);

    always_comb begin
        wstate_next = wstate_reg;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        mem_we      = 1'b0;
        case (wstate_reg)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) wstate_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    mem_we = 1'b1;
                    if (wcnt_reg == wlen_reg) wstate_next = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) wstate_next = W_IDLE;
            end
            default: wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            wstate_reg <= W_IDLE;
            wid_reg    <= '0;
            wbase_reg  <= '0;
            wlen_reg   <= '0;
            wcnt_reg   <= '0;
            werr_reg   <= 1'b0;
        end else begin
            wstate_reg <= wstate_next;
            if (awready && awvalid) begin
                wid_reg   <= awid;
                wbase_reg <= awaddr[DEPTH_LOG2+5:6];
                wlen_reg  <= awlen;
                wcnt_reg  <= '0;
                werr_reg  <= (awsize != 3'b110);
            end else if (mem_we) begin
                wcnt_reg <= wcnt_reg + 8'd1;
                // wlast must coincide exactly with the beat count; the count alone ends the burst
                if (wlast != (wcnt_reg == wlen_reg)) werr_reg <= 1'b1;
            end
        end
    end

    assign bid   = wid_reg;
    assign bresp = (bvalid && werr_reg) ? 2'b10 : 2'b00;

    // ---------------- read channel ----------------
    always_comb begin
        rstate_next = rstate_reg;
        arready     = 1'b0;
        rvalid      = 1'b0;
        rd_en       = 1'b0;
        rd_idx      = rbase_reg + idx_t'(rcnt_reg) + idx_t'(1);
        case (rstate_reg)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) rstate_next = R_FETCH;
            end
            R_FETCH: begin
                rd_en       = 1'b1;
                rd_idx      = rbase_reg;
                rstate_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready) begin
                    if (rcnt_reg == rlen_reg) rstate_next = R_IDLE;
                    else rd_en = 1'b1;
                end
            end
            default: rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            rstate_reg <= R_IDLE;
            rid_reg    <= '0;
            rbase_reg  <= '0;
            rlen_reg   <= '0;
            rcnt_reg   <= '0;
            rerr_reg   <= 1'b0;
        end else begin
            rstate_reg <= rstate_next;
            if (arready && arvalid) begin
                rid_reg   <= arid;
                rbase_reg <= araddr[DEPTH_LOG2+5:6];
                rlen_reg  <= arlen;
                rcnt_reg  <= '0;
                rerr_reg  <= (arsize != 3'b110);
            end else if (rvalid && rready && (rcnt_reg != rlen_reg)) begin
                rcnt_reg <= rcnt_reg + 8'd1;
            end
        end
    end

    assign rid   = rid_reg;
    assign rlast = rvalid && (rcnt_reg == rlen_reg);
    assign rresp = (rvalid && rerr_reg) ? 2'b10 : 2'b00;

    // One byte-wide RAM per lane so strobes map to independent write enables;
    // the lane output register doubles as the held rdata while R is stalled.
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rdata_lane_reg;

            always_ff @(posedge clk) begin
                if (mem_we && wstrb[gi]) lane_mem[w_idx] <= wdata[gi*8 +: 8];
            end

            always_ff @(posedge clk or negedge pipe_rst_n) begin
                if (!pipe_rst_n) rdata_lane_reg <= '0;
                else if (rd_en) rdata_lane_reg <= lane_mem[rd_idx];
            end

            assign rdata[gi*8 +: 8] = rdata_lane_reg;
        end
    endgenerate
endmodule

// File: tb/tb_cl_ddr_axi_responder.sv
// Randomized self-checking bench for cl_ddr_axi_responder against a word-array memory model.
module tb_cl_ddr_axi_responder;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          pipe_rst_n = 1'b0;
    logic [15:0]   awid = '0;
    logic [63:0]   awaddr = '0;
    logic [7:0]    awlen = '0;
    logic [2:0]    awsize = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [511:0]  wdata = '0;
    logic [63:0]   wstrb = '0;
    logic          wlast = 1'b0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [15:0]   bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [15:0]   arid = '0;
    logic [63:0]   araddr = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [15:0]   rid;
    logic [511:0]  rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b0;

    always #5 clk = ~clk;

    cl_ddr_axi_responder #(.DEPTH_LOG2(4), .ID_W(16)) dut (
        .clk(clk), .pipe_rst_n(pipe_rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    logic [511:0] model_mem [NW];
    logic [511:0] wd_q [256];
    logic [63:0]  ws_q [256];
    int checks = 0;
    int errors = 0;

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [511:0] apply_strb(input logic [511:0] old_w,
                                                input logic [511:0] d, input logic [63:0] s);
        logic [511:0] v;
        v = old_w;
        for (int b = 0; b < 64; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
        return v;
    endfunction

    task automatic fill_beats(input int n, input bit full_strb);
        for (int i = 0; i < n; i++) begin
            wd_q[i] = rand512();
            ws_q[i] = full_strb ? '1 : {$urandom, $urandom};
        end
    endtask

    task automatic write_burst(input logic [63:0] addr, input int len, input logic [2:0] size,
                               input int lastpos, input int bstall, input logic [15:0] id);
        int base, k, cyc;
        logic seen, exp_err;
        base = int'(addr[9:6]);
        exp_err = (size != 3'b110) || (lastpos != len);
        awaddr = addr; awlen = 8'(len); awsize = size; awid = id; awvalid = 1'b1;
        wvalid = 1'b1; wdata = wd_q[0]; wstrb = ws_q[0]; wlast = (lastpos == 0);
        checks++;
        if (wready !== 1'b0) begin
            errors++; $display("FAIL w_idle_wready got=%b exp=0", wready);
        end
        seen = 1'b0;
        for (cyc = 0; cyc < 20 && !seen; cyc++) begin
            seen = awready;
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL aw_timeout awready never seen, exp=1");
            wvalid = 1'b0; return;
        end
        k = 0;
        for (cyc = 0; cyc < 600 && k <= len; cyc++) begin
            seen = wready;
            @(posedge clk); #1;
            if (seen) begin
                model_mem[(base + k) % NW] = apply_strb(model_mem[(base + k) % NW], wd_q[k], ws_q[k]);
                k++;
                if (k <= len) begin
                    wdata = wd_q[k]; wstrb = ws_q[k]; wlast = (k == lastpos);
                end
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        checks++;
        if (k <= len) begin
            errors++; $display("FAIL w_timeout beats got=%0d exp=%0d", k, len + 1);
        end
        for (int i = 0; i < bstall; i++) begin
            checks++;
            if ({bvalid, awready, wready} !== 3'b100) begin
                errors++;
                $display("FAIL b_hold cyc=%0d got bvalid=%b awready=%b wready=%b exp 1/0/0",
                         i, bvalid, awready, wready);
            end
            @(posedge clk); #1;
        end
        bready = 1'b1;
        checks++;
        if ({bvalid, bid, bresp} !== {1'b1, id, (exp_err ? 2'b10 : 2'b00)}) begin
            errors++;
            $display("FAIL b_resp got bvalid=%b bid=%h bresp=%b exp bvalid=1 bid=%h bresp=%b",
                     bvalid, bid, bresp, id, (exp_err ? 2'b10 : 2'b00));
        end
        @(posedge clk); #1;
        bready = 1'b0;
        checks++;
        if ({bvalid, awready} !== 2'b01) begin
            errors++; $display("FAIL b_done got bvalid=%b awready=%b exp 0/1", bvalid, awready);
        end
        $display("write addr=%h len=%0d size=%b id=%h beats=%0d", addr, len, size, id, k);
    endtask

    task automatic read_burst(input logic [63:0] addr, input int len, input logic [2:0] size,
                              input logic [15:0] id, input bit toggle, input int rst_beat);
        int base, k, cyc;
        logic seen, hs;
        logic [511:0] exp_d;
        logic [1:0] eresp;
        base = int'(addr[9:6]);
        eresp = (size != 3'b110) ? 2'b10 : 2'b00;
        araddr = addr; arlen = 8'(len); arsize = size; arid = id; arvalid = 1'b1;
        seen = 1'b0;
        for (cyc = 0; cyc < 20 && !seen; cyc++) begin
            seen = arready;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL ar_timeout arready never seen, exp=1"); return;
        end
        checks++;
        if (rvalid !== 1'b0) begin
            errors++; $display("FAIL r_fetch_rvalid got=%b exp=0", rvalid);
        end
        @(posedge clk); #1;
        k = 0;
        for (cyc = 0; cyc < 1000 && k <= len; cyc++) begin
            exp_d = model_mem[(base + k) % NW];
            checks++;
            if ({rvalid, rlast, rid, rresp, rdata} !== {1'b1, (k == len), id, eresp, exp_d}) begin
                errors++;
                $display("FAIL r_beat k=%0d got v=%b l=%b id=%h resp=%b d=%h exp l=%b id=%h resp=%b d=%h",
                         k, rvalid, rlast, rid, rresp, rdata, (k == len), id, eresp, exp_d);
            end
            if (k == rst_beat) begin
                pipe_rst_n = 1'b0;
                #1;
                checks++;
                if ({rvalid, rlast, arready, awready, rdata} !== {4'b0011, 512'b0}) begin
                    errors++;
                    $display("FAIL r_reset got rvalid=%b rlast=%b arready=%b awready=%b rdata_nonzero=%b exp 0/0/1/1/0",
                             rvalid, rlast, arready, awready, |rdata);
                end
                rready = 1'b0;
                $display("read addr=%h len=%0d reset at beat %0d", addr, len, k);
                return;
            end
            rready = toggle ? (cyc % 2 == 0) : 1'b1;
            hs = rready;
            @(posedge clk); #1;
            if (hs) k++;
        end
        rready = 1'b0;
        checks++;
        if (k <= len) begin
            errors++; $display("FAIL r_timeout beats got=%0d exp=%0d", k, len + 1);
        end
        checks++;
        if ({rvalid, arready} !== 2'b01) begin
            errors++; $display("FAIL r_done got rvalid=%b arready=%b exp 0/1", rvalid, arready);
        end
        $display("read addr=%h len=%0d size=%b id=%h beats=%0d", addr, len, size, id, k);
    endtask

    task automatic test_reset();
        pipe_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid, rdata}
            !== {6'b110000, 4'b0, 32'b0, 512'b0}) begin
            errors++;
            $display("FAIL reset_state got aw=%b ar=%b w=%b b=%b r=%b rl=%b bresp=%b rresp=%b bid=%h rid=%h rdata_nz=%b exp 1/1/0/0/0/0/0/0/0/0/0",
                     awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid, |rdata);
        end
        pipe_rst_n = 1'b1;
        @(posedge clk); #1;
        $display("reset checked");
    endtask

    task automatic test_fill();
        fill_beats(16, 1'b1);
        write_burst(64'h0, 15, 3'b110, 15, 0, 16'h0F0F);
        read_burst(64'h0, 15, 3'b110, 16'h1F1F, 1'b0, -1);
    endtask

    task automatic test_write_read();
        fill_beats(4, 1'b1);
        write_burst(64'h40, 3, 3'b110, 3, 0, 16'h1234);
        read_burst(64'h40, 3, 3'b110, 16'h5678, 1'b0, -1);
    endtask

    task automatic test_strobes();
        wd_q[0] = '1; ws_q[0] = '1;
        write_burst(64'h140, 0, 3'b110, 0, 0, 16'h0005);
        wd_q[0] = '0; ws_q[0] = 64'h1;
        write_burst(64'h140, 0, 3'b110, 0, 0, 16'h0006);
        read_burst(64'h140, 0, 3'b110, 16'h0007, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        read_burst(64'h0, 7, 3'b110, 16'hBEEF, 1'b1, -1);
        fill_beats(3, 1'b0);
        write_burst(64'h80, 2, 3'b110, 2, 10, 16'hCAFE);
        read_burst(64'h80, 2, 3'b110, 16'hCAFF, 1'b1, -1);
    endtask

    task automatic test_errors();
        fill_beats(4, 1'b1);
        write_burst(64'h100, 3, 3'b110, 1, 0, 16'hE001);
        read_burst(64'h100, 3, 3'b101, 16'hE002, 1'b0, -1);
    endtask

    task automatic test_wrap();
        fill_beats(2, 1'b1);
        write_burst(64'hABCD_0000_0000_03C0, 1, 3'b110, 1, 0, 16'h00AA);
        read_burst(64'h3C5, 1, 3'b110, 16'h00AB, 1'b0, -1);
        read_burst(64'h0, 0, 3'b110, 16'h00AC, 1'b0, -1);
    endtask

    task automatic test_collision();
        logic [511:0] old_w, new_w;
        old_w = model_mem[9];
        new_w = rand512();
        awaddr = 64'h240; awlen = 8'd0; awsize = 3'b110; awid = 16'h0C0C; awvalid = 1'b1;
        araddr = 64'h7000_0240; arlen = 8'd0; arsize = 3'b110; arid = 16'h0D0D; arvalid = 1'b1;
        wvalid = 1'b1; wdata = new_w; wstrb = '1; wlast = 1'b1;
        rready = 1'b1; bready = 1'b1;
        checks++;
        if ({awready, arready} !== 2'b11) begin
            errors++; $display("FAIL coll_ready got aw=%b ar=%b exp 1/1", awready, arready);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; arvalid = 1'b0;
        checks++;
        if ({wready, rvalid} !== 2'b10) begin
            errors++; $display("FAIL coll_phase got wready=%b rvalid=%b exp 1/0", wready, rvalid);
        end
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
        model_mem[9] = new_w;
        checks++;
        if ({rvalid, rlast, rdata} !== {2'b11, old_w}) begin
            errors++;
            $display("FAIL coll_read got v=%b l=%b d=%h exp v=1 l=1 d=%h", rvalid, rlast, rdata, old_w);
        end
        checks++;
        if ({bvalid, bresp} !== 3'b100) begin
            errors++; $display("FAIL coll_b got bvalid=%b bresp=%b exp 1/00", bvalid, bresp);
        end
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
        checks++;
        if ({rvalid, bvalid, arready, awready} !== 4'b0011) begin
            errors++;
            $display("FAIL coll_done got r=%b b=%b ar=%b aw=%b exp 0/0/1/1", rvalid, bvalid, arready, awready);
        end
        $display("collision at index 9 checked");
        read_burst(64'h240, 0, 3'b110, 16'h0E0E, 1'b0, -1);
    endtask

    task automatic test_reset_mid_burst();
        read_burst(64'h200, 7, 3'b110, 16'h7777, 1'b0, 2);
        repeat (2) @(posedge clk);
        #1;
        pipe_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({rvalid, bvalid, arready, awready} !== 4'b0011) begin
                errors++;
                $display("FAIL post_reset cyc=%0d got r=%b b=%b ar=%b aw=%b exp 0/0/1/1",
                         i, rvalid, bvalid, arready, awready);
            end
        end
        read_burst(64'h200, 7, 3'b110, 16'h7778, 1'b0, -1);
    endtask

    task automatic test_random();
        int len, lastpos;
        logic [63:0] addr;
        logic [2:0] size;
        logic [15:0] id;
        for (int t = 0; t < 8; t++) begin
            len = $urandom_range(0, 15);
            addr = {$urandom, $urandom};
            size = ($urandom_range(0, 3) == 0) ? 3'b101 : 3'b110;
            lastpos = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : len;
            id = 16'($urandom);
            fill_beats(len + 1, $urandom_range(0, 1) == 1);
            write_burst(addr, len, size, lastpos, $urandom_range(0, 3), id);
            addr[5:0] = 6'($urandom);
            read_burst(addr, len, size, ~id, $urandom_range(0, 1) == 1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_strobes();
        test_backpressure();
        test_errors();
        test_wrap();
        test_collision();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
